// File: rtl/load_store_unit.sv
// Load/store unit: turns one MEMREAD/MEMWRITE request into a single req/ack
// bus transaction and returns aligned, extended load data with a done pulse.
// Misaligned or illegal accesses fault without touching the bus, and a
// request that waits too long for bus_ack is aborted with a timeout flag.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | waiting for mem_read/mem_write; checks legality/alignment
//   S_REQUEST | bus_req held high, waiting for bus_ack or timeout
//   S_DONE    | successful access, one-cycle done pulse
//   S_FAULT   | misaligned/illegal/timeout, one-cycle done pulse with flag
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_DONE,
        S_FAULT
    } state_t;

    // Last count value before the timeout fires (counter starts at 0).
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;

    logic        start;
    logic        access_ok;
    logic        legal;
    logic        aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] extracted;

    // Request decode: legality, alignment and store lane steering.
    always_comb begin
        start     = mem_write | mem_read;
        legal     = 1'b0;
        aligned   = 1'b1;
        req_be    = 4'b1111;
        req_wdata = 32'h0;
        if (mem_write) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        if (funct3[1:0] == 2'b01) begin
            aligned = (addr[0] == 1'b0);
        end else if (funct3[1:0] == 2'b10) begin
            aligned = (addr[1:0] == 2'b00);
        end
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    req_be    = 4'b0001 << addr[1:0];
                    req_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    req_be    = addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = store_data;
                end
            endcase
        end
        access_ok = legal & aligned;
    end

    // Load extraction from the returned word using the latched lane/size.
    always_comb begin
        rdata_shifted = bus_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  extracted = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  extracted = addr_lo_q[1] ? {{16{bus_rdata[31]}}, bus_rdata[31:16]}
                                              : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
            3'b100:  extracted = {24'h0, rdata_shifted[7:0]};
            3'b101:  extracted = addr_lo_q[1] ? {16'h0, bus_rdata[31:16]}
                                              : {16'h0, bus_rdata[15:0]};
            default: extracted = bus_rdata;
        endcase
    end

    // Next-state logic; ack wins over a simultaneous timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = access_ok ? S_REQUEST : S_FAULT;
                end
            end
            S_REQUEST: begin
                if (bus_ack) begin
                    state_next = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_FAULT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter, cleared on entry to REQUEST; request fields latched in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 16'h0;
            addr_lo_q <= 2'b00;
            funct3_q  <= 3'b000;
        end else begin
            if (state == S_IDLE && start) begin
                cnt       <= 16'h0;
                addr_lo_q <= addr[1:0];
                funct3_q  <= funct3;
            end else if (state == S_REQUEST && !bus_ack) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Registered outputs: status derived from the upcoming state, bus fields
    // loaded on acceptance and cleared when the transaction ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data  <= 32'h0;
            done       <= 1'b0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
        end else begin
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE) || (state_next == S_FAULT);
            misaligned <= (state == S_IDLE) && (state_next == S_FAULT);
            timeout    <= (state == S_REQUEST) && (state_next == S_FAULT);
            if (state == S_IDLE && start && access_ok) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= req_be;
                bus_wdata <= req_wdata;
            end else if (state == S_REQUEST && state_next != S_REQUEST) begin
                bus_req   <= 1'b0;
                bus_we    <= 1'b0;
                bus_addr  <= 32'h0;
                bus_be    <= 4'h0;
                bus_wdata <= 32'h0;
                if (bus_ack && !bus_we) begin
                    load_data <= extracted;
                end
            end
        end
    end

endmodule
